// File: rtl/e203_exu_oitf_pkg.sv
// Shared widths and helpers for the outstanding instruction track FIFO.
// Contents:
//   E203_RFIDX_WIDTH  register index width
//   E203_PC_SIZE      program counter width
//   E203_OITF_DEPTH   default number of outstanding long-pipe entries
//   E203_ITAG_WIDTH   entry tag width, log2 of the depth
//   rd_hit()          dependency test of one entry against one operand
package e203_exu_oitf_pkg;

  localparam int E203_RFIDX_WIDTH = 5;
  localparam int E203_PC_SIZE     = 32;
  localparam int E203_OITF_DEPTH  = 2;
  localparam int E203_ITAG_WIDTH  = $clog2(E203_OITF_DEPTH);

  // x0 is deliberately not masked; the dispatcher filters it.
  function automatic logic rd_hit(
    input logic                        ent_valid,
    input logic                        ent_rdwen,
    input logic                        ent_rdfpu,
    input logic [E203_RFIDX_WIDTH-1:0] ent_rdidx,
    input logic                        op_en,
    input logic                        op_fpu,
    input logic [E203_RFIDX_WIDTH-1:0] op_idx
  );
    return ent_valid & ent_rdwen & op_en & (ent_rdidx == op_idx) & (ent_rdfpu == op_fpu);
  endfunction

endpackage

// File: rtl/e203_exu_oitf_entry.sv
// One OITF slot: valid flag, destination payload and its dependency compare.
// Ports:
//   clk, rst_n            clock, async active-low reset (valid only)
//   set, clr              allocate / retire this slot
//   set_*                 payload captured on allocation
//   disp_i_*              operands of the instruction being dispatched
//   valid, rdwen, rdfpu, rdidx, pc   stored slot contents
//   match_rs1..3, match_rd           this slot's dependency hits
module e203_exu_oitf_entry
  import e203_exu_oitf_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        set,
  input  logic                        clr,
  input  logic                        set_rdwen,
  input  logic                        set_rdfpu,
  input  logic [E203_RFIDX_WIDTH-1:0] set_rdidx,
  input  logic [E203_PC_SIZE-1:0]     set_pc,
  input  logic                        disp_i_rs1en,
  input  logic                        disp_i_rs2en,
  input  logic                        disp_i_rs3en,
  input  logic                        disp_i_rdwen,
  input  logic                        disp_i_rs1fpu,
  input  logic                        disp_i_rs2fpu,
  input  logic                        disp_i_rs3fpu,
  input  logic                        disp_i_rdfpu,
  input  logic [E203_RFIDX_WIDTH-1:0] disp_i_rs1idx,
  input  logic [E203_RFIDX_WIDTH-1:0] disp_i_rs2idx,
  input  logic [E203_RFIDX_WIDTH-1:0] disp_i_rs3idx,
  input  logic [E203_RFIDX_WIDTH-1:0] disp_i_rdidx,
  output logic                        valid,
  output logic                        rdwen,
  output logic                        rdfpu,
  output logic [E203_RFIDX_WIDTH-1:0] rdidx,
  output logic [E203_PC_SIZE-1:0]     pc,
  output logic                        match_rs1,
  output logic                        match_rs2,
  output logic                        match_rs3,
  output logic                        match_rd
);

  // set and clr never both take effect on one slot (full blocks alloc,
  // empty blocks retire), so set wins only as a safe default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (set) begin
      valid <= 1'b1;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (set) begin
      rdwen <= set_rdwen;
      rdfpu <= set_rdfpu;
      rdidx <= set_rdidx;
      pc    <= set_pc;
    end
  end

  assign match_rs1 = rd_hit(valid, rdwen, rdfpu, rdidx, disp_i_rs1en, disp_i_rs1fpu, disp_i_rs1idx);
  assign match_rs2 = rd_hit(valid, rdwen, rdfpu, rdidx, disp_i_rs2en, disp_i_rs2fpu, disp_i_rs2idx);
  assign match_rs3 = rd_hit(valid, rdwen, rdfpu, rdidx, disp_i_rs3en, disp_i_rs3fpu, disp_i_rs3idx);
  assign match_rd  = rd_hit(valid, rdwen, rdfpu, rdidx, disp_i_rdwen, disp_i_rdfpu, disp_i_rdidx);

endmodule

// File: rtl/e203_exu_oitf.sv
// Outstanding Instruction Track FIFO: tracks long-pipe instructions in flight
// and flags RAW/WAW hazards for the instruction being dispatched.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   dis_ena / dis_ready / dis_ptr allocate, not-full, tag of next allocation
//   ret_ena / ret_ptr             retire oldest, tag of oldest
//   ret_rdidx/rdwen/rdfpu/pc      oldest entry contents (don't-care when empty)
//   disp_i_*                      dispatched instruction operands
//   oitfrd_match_disprs1..3/rd    combinational hazard hits
//   oitf_empty                    no entries outstanding
module e203_exu_oitf #(
  parameter  int E203_OITF_DEPTH = e203_exu_oitf_pkg::E203_OITF_DEPTH,
  localparam int E203_ITAG_WIDTH = $clog2(E203_OITF_DEPTH)
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            dis_ena,
  output logic                                            dis_ready,
  output logic [E203_ITAG_WIDTH-1:0]                      dis_ptr,
  input  logic                                            ret_ena,
  output logic [E203_ITAG_WIDTH-1:0]                      ret_ptr,
  output logic [e203_exu_oitf_pkg::E203_RFIDX_WIDTH-1:0]  ret_rdidx,
  output logic                                            ret_rdwen,
  output logic                                            ret_rdfpu,
  output logic [e203_exu_oitf_pkg::E203_PC_SIZE-1:0]      ret_pc,
  input  logic                                            disp_i_rs1en,
  input  logic                                            disp_i_rs2en,
  input  logic                                            disp_i_rs3en,
  input  logic                                            disp_i_rdwen,
  input  logic                                            disp_i_rs1fpu,
  input  logic                                            disp_i_rs2fpu,
  input  logic                                            disp_i_rs3fpu,
  input  logic                                            disp_i_rdfpu,
  input  logic [e203_exu_oitf_pkg::E203_RFIDX_WIDTH-1:0]  disp_i_rs1idx,
  input  logic [e203_exu_oitf_pkg::E203_RFIDX_WIDTH-1:0]  disp_i_rs2idx,
  input  logic [e203_exu_oitf_pkg::E203_RFIDX_WIDTH-1:0]  disp_i_rs3idx,
  input  logic [e203_exu_oitf_pkg::E203_RFIDX_WIDTH-1:0]  disp_i_rdidx,
  input  logic [e203_exu_oitf_pkg::E203_PC_SIZE-1:0]      disp_i_pc,
  output logic                                            oitfrd_match_disprs1,
  output logic                                            oitfrd_match_disprs2,
  output logic                                            oitfrd_match_disprs3,
  output logic                                            oitfrd_match_disprd,
  output logic                                            oitf_empty
);

  localparam int RW = e203_exu_oitf_pkg::E203_RFIDX_WIDTH;
  localparam int PW = e203_exu_oitf_pkg::E203_PC_SIZE;
  localparam logic [E203_ITAG_WIDTH:0] PTR_ONE = 1;

  // MSB is the wrap flag; depth is a power of two so +1 toggles it on wrap.
  logic [E203_ITAG_WIDTH:0] alloc_ptr_r;
  logic [E203_ITAG_WIDTH:0] ret_ptr_r;
  logic                     full;
  logic                     alloc_fire;
  logic                     ret_fire;

  assign oitf_empty = (alloc_ptr_r == ret_ptr_r);
  assign full       = (alloc_ptr_r[E203_ITAG_WIDTH-1:0] == ret_ptr_r[E203_ITAG_WIDTH-1:0]) &
                      (alloc_ptr_r[E203_ITAG_WIDTH] != ret_ptr_r[E203_ITAG_WIDTH]);
  assign dis_ready  = ~full;
  assign alloc_fire = dis_ena & ~full;
  assign ret_fire   = ret_ena & ~oitf_empty;
  assign dis_ptr    = alloc_ptr_r[E203_ITAG_WIDTH-1:0];
  assign ret_ptr    = ret_ptr_r[E203_ITAG_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_r <= '0;
      ret_ptr_r   <= '0;
    end else begin
      if (alloc_fire) alloc_ptr_r <= alloc_ptr_r + PTR_ONE;
      if (ret_fire)   ret_ptr_r   <= ret_ptr_r + PTR_ONE;
    end
  end

  logic          e_rdwen [E203_OITF_DEPTH];
  logic          e_rdfpu [E203_OITF_DEPTH];
  logic [RW-1:0] e_rdidx [E203_OITF_DEPTH];
  logic [PW-1:0] e_pc    [E203_OITF_DEPTH];
  logic [E203_OITF_DEPTH-1:0] e_valid;
  logic [E203_OITF_DEPTH-1:0] m_rs1, m_rs2, m_rs3, m_rd;

  for (genvar i = 0; i < E203_OITF_DEPTH; i++) begin : g_entry
    e203_exu_oitf_entry u_entry (
      .clk           (clk),
      .rst_n         (rst_n),
      .set           (alloc_fire & (dis_ptr == E203_ITAG_WIDTH'(i))),
      .clr           (ret_fire & (ret_ptr == E203_ITAG_WIDTH'(i))),
      .set_rdwen     (disp_i_rdwen),
      .set_rdfpu     (disp_i_rdfpu),
      .set_rdidx     (disp_i_rdidx),
      .set_pc        (disp_i_pc),
      .disp_i_rs1en  (disp_i_rs1en),
      .disp_i_rs2en  (disp_i_rs2en),
      .disp_i_rs3en  (disp_i_rs3en),
      .disp_i_rdwen  (disp_i_rdwen),
      .disp_i_rs1fpu (disp_i_rs1fpu),
      .disp_i_rs2fpu (disp_i_rs2fpu),
      .disp_i_rs3fpu (disp_i_rs3fpu),
      .disp_i_rdfpu  (disp_i_rdfpu),
      .disp_i_rs1idx (disp_i_rs1idx),
      .disp_i_rs2idx (disp_i_rs2idx),
      .disp_i_rs3idx (disp_i_rs3idx),
      .disp_i_rdidx  (disp_i_rdidx),
      .valid         (e_valid[i]),
      .rdwen         (e_rdwen[i]),
      .rdfpu         (e_rdfpu[i]),
      .rdidx         (e_rdidx[i]),
      .pc            (e_pc[i]),
      .match_rs1     (m_rs1[i]),
      .match_rs2     (m_rs2[i]),
      .match_rs3     (m_rs3[i]),
      .match_rd      (m_rd[i])
    );
  end

  assign ret_rdwen = e_rdwen[ret_ptr];
  assign ret_rdfpu = e_rdfpu[ret_ptr];
  assign ret_rdidx = e_rdidx[ret_ptr];
  assign ret_pc    = e_pc[ret_ptr];

  assign oitfrd_match_disprs1 = |m_rs1;
  assign oitfrd_match_disprs2 = |m_rs2;
  assign oitfrd_match_disprs3 = |m_rs3;
  assign oitfrd_match_disprd  = |m_rd;

endmodule
